// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store stage.
package lsu_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WAIT,
      ST_WB
   } lsu_state_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] data;
   } store_lane_t;

   // Size 2'b11 and any access that straddles its natural alignment is rejected.
   function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         MEM_BYTE: bad = 1'b0;
         MEM_HALF: bad = off[0];
         MEM_WORD: bad = (off != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte-lane mask and lane-replicated data for a store; RAM picks lanes by mask.
   function automatic store_lane_t store_lanes(input mem_size_t size,
                                               input logic [1:0] off,
                                               input logic [31:0] data);
      store_lane_t lanes;
      lanes.mask = 4'b0000;
      lanes.data = 32'h0;
      case (size)
         MEM_BYTE: begin
            lanes.mask = 4'b0001 << off;
            lanes.data = {4{data[7:0]}};
         end
         MEM_HALF: begin
            lanes.mask = off[1] ? 4'b1100 : 4'b0011;
            lanes.data = {2{data[15:0]}};
         end
         MEM_WORD: begin
            lanes.mask = 4'b1111;
            lanes.data = data;
         end
         default: begin
            lanes.mask = 4'b0000;
            lanes.data = 32'h0;
         end
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Request, RAM and write-back signals of the load/store stage.
interface lsu_stage_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_store_data;
   logic [4:0]  req_rd_addr;
   logic        rd_ram_en;
   logic [31:0] rd_ram_addr;
   logic [31:0] rd_ram_data;
   logic        wr_ram_en;
   logic [31:0] wr_ram_addr;
   logic [31:0] wr_ram_data;
   logic [3:0]  wr_ram_mask;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        misaligned;

   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned, req_addr,
             req_store_data, req_rd_addr, rd_ram_data,
      output req_ready, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr,
             wr_ram_data, wr_ram_mask, wb_valid, wb_addr, wb_data, misaligned
   );

   modport master (
      output req_valid, req_is_store, req_size, req_unsigned, req_addr,
             req_store_data, req_rd_addr, rd_ram_data,
      input  req_ready, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr,
             wr_ram_data, wr_ram_mask, wb_valid, wb_addr, wb_data, misaligned
   );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of a RAM word and extends it to 32 bits.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_byte_off,
   input  mem_size_t   i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   assign w_shifted = i_word >> {i_byte_off, 3'b000};

   // Extension by size; signedness is irrelevant for full words.
   always_comb begin
      o_data = 32'h0;
      case (i_size)
         MEM_BYTE: o_data = {{24{w_shifted[7]  & ~i_unsigned}}, w_shifted[7:0]};
         MEM_HALF: o_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
         MEM_WORD: o_data = w_shifted;
         default:  o_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between ALU and data RAM.
//
// state    | meaning
// ST_IDLE  | ready for a request; rejects misaligned ones in place
// ST_WRITE | store strobe on the RAM write port
// ST_READ  | read strobe on the RAM read port
// ST_WAIT  | counting down RAM read latency; data captured on exit
// ST_WB    | write-back strobe (suppressed for rd = 0)
//
// Every output is a flop loaded from the next-cycle values computed in the
// combinational process, so strobes line up with the state they belong to.
module lsu_stage
   import lsu_pkg::*;
#(
   parameter int RAM_RD_LATENCY = 1
)(
   input  logic        clk,
   input  logic        reset_n,
   lsu_stage_if.slave  bus
);

   localparam logic [2:0] LP_WAIT_INIT = 3'(RAM_RD_LATENCY - 1);

   lsu_state_t  r_state, w_state_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic [1:0]  r_byte_off;
   mem_size_t   r_size;
   logic        r_unsigned;
   logic [4:0]  r_rd;

   logic        r_req_ready, w_req_ready_nxt;
   logic        r_rd_en, w_rd_en_nxt;
   logic [31:0] r_rd_addr, w_rd_addr_nxt;
   logic        r_wr_en, w_wr_en_nxt;
   logic [31:0] r_wr_addr, w_wr_addr_nxt;
   logic [31:0] r_wr_data, w_wr_data_nxt;
   logic [3:0]  r_wr_mask, w_wr_mask_nxt;
   logic        r_wb_valid, w_wb_valid_nxt;
   logic [4:0]  r_wb_addr, w_wb_addr_nxt;
   logic [31:0] r_wb_data, w_wb_data_nxt;
   logic        r_mis, w_mis_nxt;
   logic        w_capture;

   logic        w_accept;
   logic        w_illegal;
   mem_size_t   w_req_size;
   store_lane_t w_lanes;
   logic [31:0] w_load_data;
   logic [31:0] w_aligned_addr;

   assign w_req_size     = mem_size_t'(bus.req_size);
   assign w_accept       = bus.req_valid & r_req_ready;
   assign w_illegal      = is_illegal(bus.req_size, bus.req_addr[1:0]);
   assign w_lanes        = store_lanes(w_req_size, bus.req_addr[1:0], bus.req_store_data);
   assign w_aligned_addr = {bus.req_addr[31:2], 2'b00};

   lsu_load_align u_align (
      .i_word     (bus.rd_ram_data),
      .i_byte_off (r_byte_off),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_data     (w_load_data)
   );

   // Next state, next outputs and request capture.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_req_ready_nxt = 1'b0;
      w_rd_en_nxt     = 1'b0;
      w_rd_addr_nxt   = 32'h0;
      w_wr_en_nxt     = 1'b0;
      w_wr_addr_nxt   = 32'h0;
      w_wr_data_nxt   = 32'h0;
      w_wr_mask_nxt   = 4'b0000;
      w_wb_valid_nxt  = 1'b0;
      w_wb_addr_nxt   = r_wb_addr;
      w_wb_data_nxt   = r_wb_data;
      w_mis_nxt       = 1'b0;
      w_capture       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready_nxt = 1'b1;
            if (w_accept) begin
               if (w_illegal) begin
                  w_mis_nxt = 1'b1;
               end else if (bus.req_is_store) begin
                  w_capture       = 1'b1;
                  w_state_nxt     = ST_WRITE;
                  w_req_ready_nxt = 1'b0;
                  w_wr_en_nxt     = 1'b1;
                  w_wr_addr_nxt   = w_aligned_addr;
                  w_wr_data_nxt   = w_lanes.data;
                  w_wr_mask_nxt   = w_lanes.mask;
               end else begin
                  w_capture       = 1'b1;
                  w_state_nxt     = ST_READ;
                  w_req_ready_nxt = 1'b0;
                  w_rd_en_nxt     = 1'b1;
                  w_rd_addr_nxt   = w_aligned_addr;
               end
            end
         end
         ST_WRITE: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = 1'b1;
         end
         ST_READ: begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_WAIT_INIT;
         end
         ST_WAIT: begin
            if (r_cnt == 3'd0) begin
               w_state_nxt = ST_WB;
               if (r_rd != 5'd0) begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_addr_nxt  = r_rd;
                  w_wb_data_nxt  = w_load_data;
               end
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         ST_WB: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = 1'b1;
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = 1'b1;
         end
      endcase
   end

   // State, captured request fields and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_byte_off  <= 2'b00;
         r_size      <= MEM_BYTE;
         r_unsigned  <= 1'b0;
         r_rd        <= 5'd0;
         r_req_ready <= 1'b1;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= 32'h0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= 32'h0;
         r_wr_data   <= 32'h0;
         r_wr_mask   <= 4'b0000;
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= 5'd0;
         r_wb_data   <= 32'h0;
         r_mis       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         if (w_capture) begin
            r_byte_off <= bus.req_addr[1:0];
            r_size     <= w_req_size;
            r_unsigned <= bus.req_unsigned;
            r_rd       <= bus.req_rd_addr;
         end
         r_req_ready <= w_req_ready_nxt;
         r_rd_en     <= w_rd_en_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_wr_mask   <= w_wr_mask_nxt;
         r_wb_valid  <= w_wb_valid_nxt;
         r_wb_addr   <= w_wb_addr_nxt;
         r_wb_data   <= w_wb_data_nxt;
         r_mis       <= w_mis_nxt;
      end
   end

   assign bus.req_ready   = r_req_ready;
   assign bus.rd_ram_en   = r_rd_en;
   assign bus.rd_ram_addr = r_rd_addr;
   assign bus.wr_ram_en   = r_wr_en;
   assign bus.wr_ram_addr = r_wr_addr;
   assign bus.wr_ram_data = r_wr_data;
   assign bus.wr_ram_mask = r_wr_mask;
   assign bus.wb_valid    = r_wb_valid;
   assign bus.wb_addr     = r_wb_addr;
   assign bus.wb_data     = r_wb_data;
   assign bus.misaligned  = r_mis;

endmodule
